// File: rtl/wb_regfile.sv
// Write-back architectural register file: two combinational read ports and a pending-write scoreboard.
// Define WB_REGFILE_BYPASS_EN to forward same-cycle write-back data and busy-clear to the read ports.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_rd_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wb_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_rd_reg_data_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    input  logic                  issue_en_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    input  logic                  pipeline_flush_flag
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_nxt;
    logic                  wb_valid;
    logic                  issue_valid;

    assign wb_valid    = wb_rd_wr_en_i && (wb_rd_addr_i != '0);
    // A flush discards the issuing instruction along with everything in flight.
    assign issue_valid = issue_en_i && (issue_rd_addr_i != '0) && !pipeline_flush_flag;

    // NOTE: the array is in the async reset because architectural state must read 0 after reset;
    // this costs a flop-based array instead of a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wb_valid) begin
            mem[wb_rd_addr_i] <= wb_rd_reg_data_i;
        end
    end

    // NOTE: defaults first so every path assigns pending_nxt and no latch is inferred.
    always_comb begin
        pending_nxt = pending;
        if (pipeline_flush_flag) begin
            pending_nxt = '0;
        end else begin
            if (wb_valid) begin
                pending_nxt[wb_rd_addr_i] = 1'b0;
            end
            // Applied after the clear so the newer instruction keeps ownership of rd.
            if (issue_valid) begin
                pending_nxt[issue_rd_addr_i] = 1'b1;
            end
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_comb begin
        rs1_data_o = (rs1_addr_i == '0) ? '0 : mem[rs1_addr_i];
        rs1_busy_o = pending[rs1_addr_i];
        rs2_data_o = (rs2_addr_i == '0) ? '0 : mem[rs2_addr_i];
        rs2_busy_o = pending[rs2_addr_i];
`ifdef WB_REGFILE_BYPASS_EN
        if (wb_valid && (wb_rd_addr_i == rs1_addr_i)) begin
            rs1_data_o = wb_rd_reg_data_i;
            rs1_busy_o = issue_valid && (issue_rd_addr_i == rs1_addr_i);
        end
        if (wb_valid && (wb_rd_addr_i == rs2_addr_i)) begin
            rs2_data_o = wb_rd_reg_data_i;
            rs2_busy_o = issue_valid && (issue_rd_addr_i == rs2_addr_i);
        end
`endif
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Architectural register file at the write-back end of the pipeline. It accepts the rd write-enable, address and data registered by the MEM/WB pipeline register and commits them. It serves two combinational read ports to the decode stage. A pending-write scoreboard lets the decode stage detect read-after-write hazards on in-flight destinations; ctrl flushes clear the scoreboard.

## Interface
Parameters:
- DATA_WIDTH, 32, register width (matches `RegBus)
- ADDR_WIDTH, 5, register index width (matches `REG_ADDR_WIDTH); NUM_REGS = 2**ADDR_WIDTH

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wb_rd_wr_en_i  input  1  write-back request from MEM/WB register
- wb_rd_addr_i  input  ADDR_WIDTH  write-back destination index
- wb_rd_reg_data_i  input  DATA_WIDTH  write-back data
- rs1_addr_i  input  ADDR_WIDTH  read port 1 index
- rs2_addr_i  input  ADDR_WIDTH  read port 2 index
- rs1_data_o  output  DATA_WIDTH  read port 1 data
- rs2_data_o  output  DATA_WIDTH  read port 2 data
- issue_en_i  input  1  decode issues an instruction that will write rd
- issue_rd_addr_i  input  ADDR_WIDTH  rd of issuing instruction
- rs1_busy_o  output  1  rs1 has a pending write
- rs2_busy_o  output  1  rs2 has a pending write
- pipeline_flush_flag  input  1  ctrl flush, discards in-flight destinations

## Operation
- Storage: NUM_REGS x DATA_WIDTH array. x0 is hardwired to 0. Writes to index 0 are dropped. Reads of index 0 return 0.
- Write: when wb_rd_wr_en_i=1 and wb_rd_addr_i!=0, mem[wb_rd_addr_i] <= wb_rd_reg_data_i at the edge.
- Read: rsN_data_o = mem[rsN_addr_i], combinational. Bypass behaviour depends on the configuration below.
- Scoreboard: a NUM_REGS-bit pending vector; bit 0 is constant 0.
  - Set: issue_en_i=1 and issue_rd_addr_i!=0 sets pending[issue_rd_addr_i].
  - Clear: a valid write-back clears pending[wb_rd_addr_i].
  - Same index set and cleared in the same cycle: set wins. The newer instruction owns rd.
  - Different indices: both take effect.
- Flush: pipeline_flush_flag=1 clears the whole pending vector at the edge. A concurrent issue is dropped. A concurrent write-back still commits to the array, because the MEM/WB contents are already architectural.
- rsN_busy_o = pending[rsN_addr_i], subject to the bypass rule. Index 0 always reads 0.

## Timing
- Reset (rst_n=0, asynchronous): all array entries 0 and pending vector 0. Consequently rs1/rs2_data_o=0 and rs1/rs2_busy_o=0 regardless of the addresses presented.
- Write latency: data is visible in the array one edge after the write-back request.
- Read latency: 0 cycles (combinational from address and state).
- Scoreboard latency: an issue at edge N makes busy visible from cycle N+1. A clear follows the write latency.
- Reset asserted mid-operation: the array and scoreboard are cleared immediately. No write completes on the edge at which rst_n is low.
- Deassertion of reset: the first write/issue is accepted on the first edge with rst_n=1.

## Configuration
- Macro WB_REGFILE_BYPASS_EN.
- Defined: write-through bypass.
  - If wb_rd_wr_en_i=1, wb_rd_addr_i!=0 and wb_rd_addr_i==rsN_addr_i, then rsN_data_o = wb_rd_reg_data_i and rsN_busy_o = 0 in that same cycle.
  - Exception: rsN_busy_o stays 1 if an issue to that index is accepted in the same cycle; it goes to 1 on the next edge.
- Undefined: no bypass. Reads return the old array value and busy reflects the registered pending bit until the edge. Decode must stall one extra cycle.

## Test plan
- Reset then read: with rst_n=0, drive rs1=5 and rs2=31 -> data 0 and busy 0. Release reset, write x5=0xDEADBEEF -> next cycle rs1_data_o=0xDEADBEEF.
- x0 protection: write x0=0xFFFFFFFF and issue rd=0 -> rs1_addr=0 gives data 0 and busy 0 on all following cycles.
- Scoreboard: issue rd=7 -> rs2_busy_o=1 for rs2=7 next cycle. Write back x7=0x12 -> busy 0 and data 0x12 the cycle after.
- Set/clear collision: with x9 pending, issue rd=9 on the same cycle as x9 write-back 0x34 -> data 0x34 and busy stays 1.
- Flush: pending x3 and x4. Assert flush together with issue rd=6 and write-back x3=0x56 -> next cycle busy 0 for x3, x4 and x6, and x3 reads 0x56.
- Bypass (macro defined): x10 pending. Write-back x10=0xA5A5A5A5 with rs1=10 -> same cycle rs1_data_o=0xA5A5A5A5 and rs1_busy_o=0. With the macro undefined -> old value and busy 1 until the edge.
